// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider issue arbiter slice.
package div_arbiter_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned ROB_IDX_LEN     = 4;
  localparam int unsigned EXCEPT_CODE_LEN = 5;

  typedef logic [ROB_IDX_LEN-1:0]     rob_idx_t;
  typedef logic [EXCEPT_CODE_LEN-1:0] except_code_t;

  localparam logic [3:0] DIV_DIV  = 4'd0;
  localparam logic [3:0] DIV_DIVU = 4'd1;
  localparam logic [3:0] DIV_REM  = 4'd2;
  localparam logic [3:0] DIV_REMU = 4'd3;

  typedef enum logic {
    IDLE,
    WAIT
  } div_arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        idx_o    = IW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one non-pipelined serial divider between N_REQ requesters:
// round-robin issue with grant lock, single op in flight, result routed to owner.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned EU_CTL_LEN = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ*EU_CTL_LEN-1:0]         req_ctl_i,
  input  logic [N_REQ*$bits(rob_idx_t)-1:0]   req_rob_idx_i,
  input  logic [N_REQ*XLEN-1:0]               req_rs1_i,
  input  logic [N_REQ*XLEN-1:0]               req_rs2_i,
  output logic [N_REQ-1:0]                    rsp_valid_o,
  input  logic [N_REQ-1:0]                    rsp_ready_i,
  output logic [$bits(rob_idx_t)-1:0]         rsp_rob_idx_o,
  output logic [XLEN-1:0]                     rsp_result_o,
  output logic                                rsp_except_raised_o,
  output logic [$bits(except_code_t)-1:0]     rsp_except_code_o,
  output logic                                div_valid_o,
  input  logic                                div_ready_i,
  output logic [EU_CTL_LEN-1:0]               div_ctl_o,
  output logic [$bits(rob_idx_t)-1:0]         div_rob_idx_o,
  output logic [XLEN-1:0]                     div_rs1_o,
  output logic [XLEN-1:0]                     div_rs2_o,
  input  logic                                div_valid_i,
  output logic                                div_ready_o,
  input  logic [$bits(rob_idx_t)-1:0]         div_rob_idx_i,
  input  logic [XLEN-1:0]                     div_result_i,
  input  logic                                div_except_raised_i,
  input  logic [$bits(except_code_t)-1:0]     div_except_code_i,
  output logic                                div_flush_o,
  output logic                                busy_o
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned RW = $bits(rob_idx_t);

  div_arb_state_t   state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    locked_id;
  logic [IW-1:0]    owner;
  logic             lock;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [IW-1:0]    g;
  logic [N_REQ-1:0] sel_oh;
  logic             issue_valid;
  logic             idle_live;
  logic             wait_live;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  // A held lock overrides the round-robin pick so the payload stays stable.
  always_comb begin
    g           = lock ? locked_id : arb_idx;
    sel_oh      = lock ? (N_REQ'(1) << locked_id) : arb_gnt;
    issue_valid = lock ? req_valid_i[locked_id] : arb_any;
    idle_live   = (state == IDLE) && !flush_i;
    wait_live   = (state == WAIT) && !flush_i;

    div_valid_o = idle_live && issue_valid;
    req_ready_o = (idle_live && div_ready_i) ? sel_oh : '0;

    div_ctl_o     = '0;
    div_rob_idx_o = '0;
    div_rs1_o     = '0;
    div_rs2_o     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (g == IW'(k)) begin
        div_ctl_o     = req_ctl_i[k*EU_CTL_LEN +: EU_CTL_LEN];
        div_rob_idx_o = req_rob_idx_i[k*RW +: RW];
        div_rs1_o     = req_rs1_i[k*XLEN +: XLEN];
        div_rs2_o     = req_rs2_i[k*XLEN +: XLEN];
      end
    end

    rsp_valid_o = '0;
    if (wait_live && div_valid_i) begin
      rsp_valid_o = N_REQ'(1) << owner;
    end
    div_ready_o = wait_live && rsp_ready_i[owner];
  end

  assign rsp_rob_idx_o       = div_rob_idx_i;
  assign rsp_result_o        = div_result_i;
  assign rsp_except_raised_o = div_except_raised_i;
  assign rsp_except_code_o   = div_except_code_i;
  assign div_flush_o         = flush_i;
  assign busy_o              = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      locked_id <= '0;
      owner     <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      lock  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid_o && div_ready_i) begin
            owner  <= g;
            rr_ptr <= IW'(rr_next(32'(g), N_REQ));
            lock   <= 1'b0;
            state  <= WAIT;
          end else if (div_valid_o) begin
            lock      <= 1'b1;
            locked_id <= g;
          end else begin
            lock <= 1'b0;
          end
        end
        WAIT: begin
          if (div_valid_i && div_ready_o) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table plus directed lock/backpressure/flush/reset sequences.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned CL = 4;
  localparam int unsigned RW = $bits(rob_idx_t);

  logic                 clk_i;
  logic                 rst_i;
  logic                 flush_i;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  logic [N*CL-1:0]      req_ctl_i;
  logic [N*RW-1:0]      req_rob_idx_i;
  logic [N*XLEN-1:0]    req_rs1_i;
  logic [N*XLEN-1:0]    req_rs2_i;
  logic [N-1:0]         rsp_valid_o;
  logic [N-1:0]         rsp_ready_i;
  logic [RW-1:0]        rsp_rob_idx_o;
  logic [XLEN-1:0]      rsp_result_o;
  logic                 rsp_except_raised_o;
  except_code_t         rsp_except_code_o;
  logic                 div_valid_o;
  logic                 div_ready_i;
  logic [CL-1:0]        div_ctl_o;
  logic [RW-1:0]        div_rob_idx_o;
  logic [XLEN-1:0]      div_rs1_o;
  logic [XLEN-1:0]      div_rs2_o;
  logic                 div_valid_i;
  logic                 div_ready_o;
  logic [RW-1:0]        div_rob_idx_i;
  logic [XLEN-1:0]      div_result_i;
  logic                 div_except_raised_i;
  except_code_t         div_except_code_i;
  logic                 div_flush_o;
  logic                 busy_o;

  div_arbiter #(.N_REQ(N), .EU_CTL_LEN(CL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ctl_i(req_ctl_i),
    .req_rob_idx_i(req_rob_idx_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rob_idx_o(rsp_rob_idx_o),
    .rsp_result_o(rsp_result_o), .rsp_except_raised_o(rsp_except_raised_o),
    .rsp_except_code_o(rsp_except_code_o),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i), .div_ctl_o(div_ctl_o),
    .div_rob_idx_o(div_rob_idx_o), .div_rs1_o(div_rs1_o), .div_rs2_o(div_rs2_o),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o), .div_rob_idx_i(div_rob_idx_i),
    .div_result_i(div_result_i), .div_except_raised_i(div_except_raised_i),
    .div_except_code_i(div_except_code_i), .div_flush_o(div_flush_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    int unsigned g;
    rob_idx_t    rob;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  vmask;
    logic [31:0] a0, b0;
    rob_idx_t    rob0;
    logic [31:0] a1, b1;
    rob_idx_t    rob1;
    int unsigned exp_g;
    logic [31:0] exp_res;
    rob_idx_t    exp_rob;
  } vec_t;

  logic [31:0] cap_a, cap_b;
  rob_idx_t    cap_rob;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int unsigned g);
    return N'(1) << g;
  endfunction

  task automatic set_req(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                         input rob_idx_t rob);
    req_valid_i[r]            = 1'b1;
    req_ctl_i[r*CL +: CL]     = DIV_DIVU;
    req_rs1_i[r*XLEN +: XLEN] = a;
    req_rs2_i[r*XLEN +: XLEN] = b;
    req_rob_idx_i[r*RW +: RW] = rob;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Called at a negedge while an issue is expected; captures what the divider latches.
  task automatic check_issue(input string tag, input int unsigned g, input rob_idx_t rob);
    chk({tag, "_div_valid"}, div_valid_o, 1);
    chk({tag, "_req_ready"}, req_ready_o, div_ready_i ? oh(g) : '0);
    chk({tag, "_div_rob"}, div_rob_idx_o, rob);
    chk({tag, "_div_ctl"}, div_ctl_o, DIV_DIVU);
    cap_a   = div_rs1_o;
    cap_b   = div_rs2_o;
    cap_rob = div_rob_idx_o;
  endtask

  task automatic divider_respond();
    div_valid_i         = 1'b1;
    div_result_i        = (cap_b == 0) ? '1 : cap_a / cap_b;
    div_rob_idx_i       = cap_rob;
    div_except_raised_i = 1'b0;
    div_except_code_i   = '0;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, rsp_valid_o, oh(e.g));
      chk({tag, "_rsp_result"}, rsp_result_o, e.res);
      chk({tag, "_rsp_rob"}, rsp_rob_idx_o, e.rob);
      chk({tag, "_div_ready"}, div_ready_o, 1);
    end
  endtask

  // From posedge+1 in WAIT with div_ready_i low: hold, return result, end at posedge+1 in IDLE.
  task automatic wait_and_respond(input string tag);
    @(negedge clk_i);
    chk({tag, "_busy_wait"}, busy_o, 1);
    chk({tag, "_no_issue"}, div_valid_o, 0);
    chk({tag, "_no_ready"}, req_ready_o, '0);
    next_cycle();
    divider_respond();
    @(negedge clk_i);
    check_rsp(tag);
    next_cycle();
    div_valid_i = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    req_valid_i = '0;
    if (v.vmask[0]) set_req(0, v.a0, v.b0, v.rob0);
    if (v.vmask[1]) set_req(1, v.a1, v.b1, v.rob1);
    div_ready_i = 1'b1;
    rsp_ready_i = '1;
    sb.push_back('{g: v.exp_g, rob: v.exp_rob, res: v.exp_res});
    @(negedge clk_i);
    check_issue(tag, v.exp_g, v.exp_rob);
    chk({tag, "_busy_idle"}, busy_o, 0);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    wait_and_respond(tag);
    @(negedge clk_i);
    chk({tag, "_bubble_idle"}, busy_o, 0);
    next_cycle();
  endtask

  // Protocol checks on the bench's own stimulus.
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_v     = '0;
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i) begin
      assert (!(div_valid_i && !busy_o))
        else $error("FAIL proto_div_valid_in_idle: got 1 expected 0");
      assert (!(prev_stall && ((req_valid_i & prev_v) == '0)))
        else $error("FAIL proto_locked_drop: got 0 expected nonzero");
    end
    prev_stall <= div_valid_o && !div_ready_i && !rst_i && !flush_i;
    prev_v     <= req_valid_i;
  end

  vec_t tbl[10];
  vec_t pre;

  initial begin
    tbl[0] = '{2'b01,  100,  7,  3,   0, 0,  0, 0, 32'd14,  3};
    tbl[1] = '{2'b11,   50,  5,  1,  81, 9,  2, 1, 32'd9,   2};
    tbl[2] = '{2'b11,   50,  5,  1,  81, 9,  2, 0, 32'd10,  1};
    tbl[3] = '{2'b11, 1000, 10,  4,  77, 7,  5, 1, 32'd11,  5};
    tbl[4] = '{2'b11, 1000, 10,  4,  77, 7,  5, 0, 32'd100, 4};
    tbl[5] = '{2'b01,    9,  2,  6,   0, 0,  0, 0, 32'd4,   6};
    tbl[6] = '{2'b10,    0,  0,  0,   7, 0,  7, 1, 32'hFFFF_FFFF, 7};
    tbl[7] = '{2'b10,    0,  0,  0, 255, 16, 8, 1, 32'd15,  8};
    tbl[8] = '{2'b11,    3,  3,  9,   1, 2, 10, 0, 32'd1,   9};
    tbl[9] = '{2'b11,    6,  3, 11,  40, 4, 12, 1, 32'd10, 12};

    rst_i = 1'b1; flush_i = 1'b0;
    req_valid_i = '0; req_ctl_i = '0; req_rob_idx_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    rsp_ready_i = '0; div_ready_i = 1'b0; div_valid_i = 1'b0; div_rob_idx_i = '0;
    div_result_i = '0; div_except_raised_i = 1'b0; div_except_code_i = '0;
    cap_a = '0; cap_b = '0; cap_rob = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, '0);
    chk("rst_rsp_valid", rsp_valid_o, '0);
    chk("rst_div_valid", div_valid_o, 0);
    chk("rst_div_ready", div_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_div_flush", div_flush_o, 0);
    next_cycle();

    for (int i = 0; i < 10; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Grant lock: req1 stalls, req0 joins mid-stall; req1 must stay granted.
    req_valid_i = '0;
    set_req(1, 500, 25, 13);
    div_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_req(0, 60, 6, 14);
      @(negedge clk_i);
      chk("lock_div_valid", div_valid_o, 1);
      chk("lock_rs1_stable", div_rs1_o, 500);
      chk("lock_rob_stable", div_rob_idx_o, 13);
      chk("lock_req_ready", req_ready_o, '0);
      next_cycle();
    end
    div_ready_i = 1'b1;
    sb.push_back('{g: 1, rob: 13, res: 20});
    @(negedge clk_i);
    check_issue("lock_acc1", 1, 13);
    next_cycle();
    req_valid_i[1] = 1'b0;
    div_ready_i = 1'b0;
    wait_and_respond("lock_op1");
    div_ready_i = 1'b1;
    sb.push_back('{g: 0, rob: 14, res: 10});
    @(negedge clk_i);
    check_issue("lock_acc0", 0, 14);
    chk("lock_after_bubble_busy", busy_o, 0);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    wait_and_respond("lock_op0");

    // Result backpressure with a competing request pending.
    set_req(0, 144, 12, 1);
    div_ready_i = 1'b1;
    sb.push_back('{g: 0, rob: 1, res: 12});
    @(negedge clk_i);
    check_issue("bp_acc0", 0, 1);
    next_cycle();
    req_valid_i = '0;
    set_req(1, 90, 9, 2);
    rsp_ready_i = 2'b10;
    divider_respond();
    div_except_raised_i = 1'b1;
    div_except_code_i   = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bp_div_ready_low", div_ready_o, 0);
      chk("bp_rsp_held", rsp_valid_o, 2'b01);
      chk("bp_result_held", rsp_result_o, 12);
      chk("bp_except_raised", rsp_except_raised_o, 1);
      chk("bp_except_code", rsp_except_code_o, 3);
      chk("bp_no_issue", div_valid_o, 0);
      chk("bp_no_req_ready", req_ready_o, '0);
      next_cycle();
    end
    rsp_ready_i = '1;
    @(negedge clk_i);
    check_rsp("bp_rsp");
    next_cycle();
    div_valid_i = 1'b0;
    div_except_raised_i = 1'b0;
    div_except_code_i = '0;
    sb.push_back('{g: 1, rob: 2, res: 10});
    @(negedge clk_i);
    check_issue("bp_acc1", 1, 2);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    wait_and_respond("bp_op1");

    // Flush in WAIT while the result arrives; the result is dropped.
    set_req(0, 21, 7, 5);
    div_ready_i = 1'b1;
    @(negedge clk_i);
    check_issue("fl_acc0", 0, 5);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    @(negedge clk_i);
    chk("fl_busy", busy_o, 1);
    next_cycle();
    divider_respond();
    flush_i = 1'b1;
    set_req(1, 64, 8, 7);
    div_ready_i = 1'b1;
    @(negedge clk_i);
    chk("fl_div_flush", div_flush_o, 1);
    chk("fl_rsp_valid", rsp_valid_o, '0);
    chk("fl_div_ready", div_ready_o, 0);
    chk("fl_div_valid", div_valid_o, 0);
    chk("fl_req_ready", req_ready_o, '0);
    next_cycle();
    flush_i = 1'b0;
    div_valid_i = 1'b0;
    set_req(0, 45, 9, 6);
    sb.push_back('{g: 1, rob: 7, res: 8});
    @(negedge clk_i);
    chk("fl_post_flush_off", div_flush_o, 0);
    chk("fl_post_idle", busy_o, 0);
    check_issue("fl_acc1", 1, 7);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    wait_and_respond("fl_op1");

    // Synchronous reset during a locked issue clears lock and pointer.
    pre = '{2'b01, 30, 5, 8, 0, 0, 0, 0, 32'd6, 8};
    apply_vec("rs_pre", pre);
    set_req(1, 77, 11, 9);
    div_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rs_stall_valid", div_valid_o, 1);
    next_cycle();
    @(negedge clk_i);
    chk("rs_lock_rs1", div_rs1_o, 77);
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    req_valid_i = '0;
    @(negedge clk_i);
    chk("rs_req_ready", req_ready_o, '0);
    chk("rs_rsp_valid", rsp_valid_o, '0);
    chk("rs_div_valid", div_valid_o, 0);
    chk("rs_div_ready", div_ready_o, 0);
    chk("rs_busy", busy_o, 0);
    chk("rs_div_flush", div_flush_o, 0);
    next_cycle();
    set_req(0, 88, 8, 10);
    set_req(1, 77, 11, 9);
    div_ready_i = 1'b1;
    sb.push_back('{g: 0, rob: 10, res: 11});
    @(negedge clk_i);
    check_issue("rs_acc0", 0, 10);
    next_cycle();
    req_valid_i = '0;
    div_ready_i = 1'b0;
    wait_and_respond("rs_op0");

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one serial integer divider execution unit between N_REQ reservation-station requesters, e.g. the integer RS and the address/CSR side path.
- Arbitrates issue with a round-robin scheme and locks the grant until the divider accepts.
- Allows exactly one operation in flight, since the serial divider is not pipelined.
- Routes the result, ROB index and exception info back to the owning requester; propagates flush to the divider.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- EU_CTL_LEN, 4, width of the divider control field (div op encoding).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush
- req_valid_i  in  N_REQ  per-requester issue valid
- req_ready_o  out  N_REQ  per-requester issue ready
- req_ctl_i  in  N_REQ*EU_CTL_LEN  per-requester div control, packed, requester 0 in LSBs
- req_rob_idx_i  in  N_REQ*$bits(rob_idx_t)  per-requester ROB index, packed
- req_rs1_i  in  N_REQ*XLEN  per-requester operand a, packed
- req_rs2_i  in  N_REQ*XLEN  per-requester operand b, packed
- rsp_valid_o  out  N_REQ  one-hot result valid
- rsp_ready_i  in  N_REQ  per-requester result ready
- rsp_rob_idx_o  out  $bits(rob_idx_t)  shared result ROB index
- rsp_result_o  out  XLEN  shared result
- rsp_except_raised_o  out  1  shared exception flag
- rsp_except_code_o  out  $bits(except_code_t)  shared exception code
- div_valid_o  out  1  issue valid to divider
- div_ready_i  in  1  divider input ready
- div_ctl_o  out  EU_CTL_LEN  granted ctl
- div_rob_idx_o  out  $bits(rob_idx_t)  granted ROB index
- div_rs1_o  out  XLEN  granted operand a
- div_rs2_o  out  XLEN  granted operand b
- div_valid_i  in  1  divider result valid
- div_ready_o  out  1  ready to divider output
- div_rob_idx_i  in  $bits(rob_idx_t)  divider result ROB index
- div_result_i  in  XLEN  divider result
- div_except_raised_i  in  1  divider exception
- div_except_code_i  in  $bits(except_code_t)  divider exception code
- div_flush_o  out  1  flush to divider
- busy_o  out  1  operation in flight (state != IDLE)

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - State registers: state=IDLE, rr_ptr=0, lock=0, owner=0.
  - Outputs: all valid/ready outputs 0, busy_o=0; data outputs are don't-care but driven with no X (muxed from registers/inputs).
- FSM states: IDLE (no op in flight) and WAIT (op accepted by the divider, result pending).
- IDLE arbitration:
  - The grant g is the first requester with valid set, searching from rr_ptr upward modulo N_REQ. If lock=1, g=locked_id.
  - div_valid_o = req_valid_i[g]; the div_* payload is muxed from requester g.
  - req_ready_o[g] = div_ready_i; all other req_ready_o are 0.
  - If div_valid_o=1 and div_ready_i=0: lock<=1, locked_id<=g. The payload stays stable, which the divider's stable-handshake requirement needs.
  - If the locked requester drops its valid: lock<=0 and arbitration is recomputed next cycle. This is a protocol violation; the bench checks it with an assertion.
  - On handshake (div_valid_o & div_ready_i): owner<=g, rr_ptr<=(g+1) mod N_REQ, lock<=0, state<=WAIT.
  - Issue is combinational, so the arbiter adds zero cycles of issue latency.
- WAIT:
  - req_ready_o=0 and div_valid_o=0.
  - rsp_valid_o = div_valid_i one-hot at owner; rsp_* data pass through from div_*_i.
  - div_ready_o = rsp_ready_i[owner].
  - On result handshake: state<=IDLE. The next grant is issued in the following cycle, giving one bubble per op.
- div_ready_o is 0 in IDLE. A div_valid_i seen in IDLE is an error and is flagged by an assertion.
- Flush:
  - div_flush_o = flush_i (combinational).
  - In the flush cycle, all req_ready_o, rsp_valid_o, div_valid_o and div_ready_o are 0.
  - Next state: IDLE with lock=0; rr_ptr is kept.
  - A flush takes effect in any state, including a pending lock or a result arriving in the same cycle. That result is dropped.
- Reset mid-operation: same as flush, except rr_ptr=0 and div_flush_o is not asserted. The divider has its own reset.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ-1 grants.
- Fairness pointer: advances only on an accepted issue. It does not advance on a lock or a flush.

Decomposition:
- expipe_pkg: add div_arb_state_t (IDLE, WAIT).
- rob_idx_t, except_code_t, XLEN and the div ctl encodings stay in the existing len5_pkg/expipe_pkg.
- Sub-module rr_arbiter (N parameter): inputs req vector and pointer; outputs one-hot grant and index. It is reusable by other shared-EU arbiters.

Test Plan:
- Single requester: req0 issues DIVU 100/7, rob_idx 3 -> div_valid_o the same cycle; after the divider result, rsp_valid_o=01, rsp_result_o=14, rsp_rob_idx_o=3; busy_o high only during WAIT.
- Contention: req0 and req1 both valid for 4 ops each -> grants alternate 0,1,0,1,...; each response goes only to its issuer; rr_ptr ends at 0.
- Grant lock: req1 valid while div_ready_i=0 for 5 cycles, then req0 also asserts -> div_* payload stays stable on req1; req1 is accepted first, then req0.
- Backpressure: result ready with rsp_ready_i[owner]=0 for 3 cycles -> div_ready_o=0 and the result is held; no new issue until the result handshake; exactly one bubble after it.
- Flush in WAIT with div_valid_i=1 in the same cycle -> div_flush_o=1, no rsp_valid_o, state IDLE next cycle; a new request is issued on the following cycle.
- Synchronous reset asserted during a locked issue -> next cycle all valid/ready outputs 0, rr_ptr=0, busy_o=0.
